// File: rtl/store_retire_buffer_pkg.sv
// Shared types for the post-retire store buffer: bus command, entry and FSM state.
package store_retire_buffer_pkg;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'd0,
    BUS_LOAD  = 2'd1,
    BUS_STORE = 2'd2
  } BUS_COMMAND;

  typedef enum logic [1:0] {
    SB_IDLE  = 2'd0,
    SB_DRAIN = 2'd1,
    SB_FLUSH = 2'd2,
    SB_DONE  = 2'd3
  } SB_STATE;

  // One buffered 8-byte block; blk is address bits [63:3].
  typedef struct packed {
    logic        valid;
    logic [60:0] blk;
    logic [63:0] data;
  } SB_ENTRY;

  // Rebuild the byte address of a block.
  function automatic logic [63:0] blk2addr(input logic [60:0] b);
    return {b, 3'b000};
  endfunction

endpackage

// File: rtl/store_retire_buffer_fwd_cam.sv
// Load-forwarding search: finds the youngest valid entry holding the load's block.
module sb_fwd_cam
  import store_retire_buffer_pkg::*;
#(
  parameter int SB_DEPTH = 4
) (
  input  SB_ENTRY [SB_DEPTH-1:0]         ent_i,
  input  logic    [$clog2(SB_DEPTH)-1:0] tail_i,
  input  logic    [60:0]                 blk_i,
  output logic                           hit_o,
  output logic    [63:0]                 data_o
);

  localparam int PW = $clog2(SB_DEPTH);

  logic [PW-1:0] idx;

  // Walk from tail (oldest slot) around to tail-1 (youngest); the last match wins.
  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    idx    = '0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      idx = tail_i + PW'(i);
      if (ent_i[idx].valid && ent_i[idx].blk == blk_i) begin
        hit_o  = 1'b1;
        data_o = ent_i[idx].data;
      end
    end
  end

endmodule

// File: rtl/store_retire_buffer.sv
// Post-retire store FIFO: coalesces same-block stores, drains in order to the
// memory bus behind D-cache misses, forwards to loads, and flushes on halt.
module store_retire_buffer
  import store_retire_buffer_pkg::*;
#(
  parameter int SB_DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        st_valid,
  input  logic [63:0] st_addr,
  input  logic [63:0] st_data,
  output logic        st_ready,
  input  logic        halt_req,
  input  logic        ld_busy,
  input  logic [63:0] ld_addr,
  output logic        ld_hit,
  output logic [63:0] ld_data,
  output BUS_COMMAND  proc2mem_command,
  output logic [63:0] proc2mem_addr,
  output logic [63:0] proc2mem_data,
  input  logic [3:0]  mem2proc_response,
  output logic        sb_empty,
  output logic        drained
);

  localparam int            PW   = $clog2(SB_DEPTH);
  localparam logic [PW:0]   FULL = (PW+1)'(SB_DEPTH);

  SB_ENTRY [SB_DEPTH-1:0] ent_q;
  logic    [PW-1:0]       head_q, tail_q, tail_m1;
  logic    [PW:0]         count_q, count_d;
  SB_STATE                state_q;
  logic                   drained_q;
  logic                   closed, issue, pop, coal, enq;
  logic                   unused_addr_bits;

  assign unused_addr_bits = ^{st_addr[2:0], ld_addr[2:0]};

  assign tail_m1 = tail_q - PW'(1);
  // Once halted, retire must not hand us more stores.
  assign closed   = (state_q == SB_FLUSH) || (state_q == SB_DONE);
  assign st_ready = (count_q < FULL) && !closed;

  assign issue = ((state_q == SB_DRAIN) || (state_q == SB_FLUSH)) &&
                 (count_q != '0) && !ld_busy;
  assign pop   = issue && (mem2proc_response != 4'h0);

  // Merge into the youngest entry unless it is the head currently on the bus,
  // whose data the memory may be latching this very cycle.
  assign coal = st_valid && !closed && ent_q[tail_m1].valid &&
                (ent_q[tail_m1].blk == st_addr[63:3]) &&
                !((tail_m1 == head_q) && issue);
  assign enq  = st_valid && st_ready && !coal;

  assign count_d = count_q + (PW+1)'(enq) - (PW+1)'(pop);

  // Entry array and FIFO pointers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ent_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (coal) ent_q[tail_m1].data <= st_data;
      if (pop) begin
        ent_q[head_q].valid <= 1'b0;
        head_q              <= head_q + PW'(1);
      end
      if (enq) begin
        ent_q[tail_q] <= '{valid: 1'b1, blk: st_addr[63:3], data: st_data};
        tail_q        <= tail_q + PW'(1);
      end
      count_q <= count_d;
    end
  end

  // Drain/flush FSM; drained follows DONE by one cycle and latches with it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= SB_IDLE;
      drained_q <= 1'b0;
    end else begin
      drained_q <= (state_q == SB_DONE);
      case (state_q)
        SB_IDLE, SB_DRAIN: begin
          if (halt_req)              state_q <= (count_d == '0) ? SB_DONE : SB_FLUSH;
          else if (count_d != '0)    state_q <= SB_DRAIN;
          else                       state_q <= SB_IDLE;
        end
        SB_FLUSH: if (count_d == '0) state_q <= SB_DONE;
        default:                     state_q <= SB_DONE;
      endcase
    end
  end

  sb_fwd_cam #(.SB_DEPTH(SB_DEPTH)) u_cam (
    .ent_i  (ent_q),
    .tail_i (tail_q),
    .blk_i  (ld_addr[63:3]),
    .hit_o  (ld_hit),
    .data_o (ld_data)
  );

  assign proc2mem_command = issue ? BUS_STORE : BUS_NONE;
  assign proc2mem_addr    = issue ? blk2addr(ent_q[head_q].blk) : '0;
  assign proc2mem_data    = issue ? ent_q[head_q].data : '0;
  assign sb_empty         = (count_q == '0);
  assign drained          = drained_q;

endmodule

// File: tb/tb_store_retire_buffer.sv
// Bench for store_retire_buffer: directed scenarios plus random traffic,
// all checked against a queue-based model of the buffer.
module tb_store_retire_buffer;
  import store_retire_buffer_pkg::*;

  localparam int D = 4;

  logic        clock = 1'b0, reset = 1'b0;
  logic        st_valid = 1'b0, halt_req = 1'b0, ld_busy = 1'b0;
  logic [63:0] st_addr = '0, st_data = '0, ld_addr = '0;
  logic [3:0]  mem2proc_response = '0;
  logic        st_ready, ld_hit, sb_empty, drained;
  logic [63:0] ld_data, proc2mem_addr, proc2mem_data;
  BUS_COMMAND  proc2mem_command;

  int tot = 0, bad = 0;

  always #5 clock = ~clock;

  store_retire_buffer #(.SB_DEPTH(D)) dut (
    .clock(clock), .reset(reset),
    .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_ready(st_ready),
    .halt_req(halt_req), .ld_busy(ld_busy), .ld_addr(ld_addr),
    .ld_hit(ld_hit), .ld_data(ld_data),
    .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr),
    .proc2mem_data(proc2mem_data), .mem2proc_response(mem2proc_response),
    .sb_empty(sb_empty), .drained(drained)
  );

  // Reference model: an ordered list of buffered blocks plus halt progress.
  typedef struct { logic [60:0] blk; logic [63:0] data; } ment_t;
  ment_t mq[$];
  bit    m_halt, m_done, m_drained;

  logic        e_ready, e_issue, e_coal, e_enq, e_hit, e_empty;
  logic [63:0] e_ldata, e_addr, e_data;
  BUS_COMMAND  e_cmd;

  function automatic void model_eval();
    e_empty = (mq.size() == 0);
    e_ready = (mq.size() < D) && !m_halt;
    e_issue = (mq.size() > 0) && !ld_busy;
    e_cmd   = e_issue ? BUS_STORE : BUS_NONE;
    e_addr  = e_issue ? {mq[0].blk, 3'b000} : 64'h0;
    e_data  = e_issue ? mq[0].data : 64'h0;
    e_coal  = st_valid && !m_halt && (mq.size() > 0) &&
              (mq[mq.size()-1].blk == st_addr[63:3]) &&
              !((mq.size() == 1) && e_issue);
    e_enq   = st_valid && e_ready && !e_coal;
    e_hit   = 1'b0;
    e_ldata = 64'h0;
    foreach (mq[i]) if (mq[i].blk == ld_addr[63:3]) begin
      e_hit   = 1'b1;
      e_ldata = mq[i].data;
    end
  endfunction

  task automatic tick();
    ment_t t;
    model_eval();
    @(posedge clock);
    if (e_coal) begin
      t = mq[mq.size()-1];
      t.data = st_data;
      mq[mq.size()-1] = t;
    end
    if (e_issue && mem2proc_response != 4'h0) void'(mq.pop_front());
    if (e_enq) begin
      t.blk  = st_addr[63:3];
      t.data = st_data;
      mq.push_back(t);
    end
    m_drained = m_drained | m_done;
    if (halt_req) m_halt = 1'b1;
    if (m_halt && mq.size() == 0) m_done = 1'b1;
    @(negedge clock);
  endtask

  task automatic idle_in();
    st_valid = 1'b0; halt_req = 1'b0; ld_busy = 1'b0; mem2proc_response = 4'h0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    idle_in();
    mq.delete(); m_halt = 0; m_done = 0; m_drained = 0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    tot++; if (st_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b exp=1", st_ready); end
    tot++; if (sb_empty !== 1'b1) begin bad++; $display("FAIL rst_empty got=%b exp=1", sb_empty); end
    tot++; if (proc2mem_command !== BUS_NONE || proc2mem_addr !== 64'h0 || proc2mem_data !== 64'h0)
      begin bad++; $display("FAIL rst_bus got=%0d/%h/%h exp=0/0/0", proc2mem_command, proc2mem_addr, proc2mem_data); end
    tot++; if (ld_hit !== 1'b0 || ld_data !== 64'h0 || drained !== 1'b0)
      begin bad++; $display("FAIL rst_misc got=%b/%h/%b exp=0/0/0", ld_hit, ld_data, drained); end
    @(negedge clock);
  endtask

  // Four distinct blocks fill the buffer; a fifth block is refused, a repeat of the tail coalesces.
  task automatic test_fill();
    for (int k = 0; k < 4; k++) begin
      idle_in(); st_valid = 1'b1; st_addr = 64'h100 + 64'(k*8); st_data = 64'hA0 + 64'(k);
      #1; model_eval();
      tot++; if (st_ready !== 1'b1) begin bad++; $display("FAIL fill_ready%0d got=%b exp=1", k, st_ready); end
      tick();
    end
    idle_in(); st_valid = 1'b1; st_addr = 64'h120; st_data = 64'hBAD; ld_addr = 64'h120;
    #1;
    tot++; if (st_ready !== 1'b0) begin bad++; $display("FAIL fill_full got=%b exp=0", st_ready); end
    tick();
    idle_in(); #1;
    tot++; if (ld_hit !== 1'b0) begin bad++; $display("FAIL fill_5th_dropped hit got=%b exp=0", ld_hit); end
    st_valid = 1'b1; st_addr = 64'h118; st_data = 64'hC0A1E5CE;
    tick();
    idle_in(); ld_addr = 64'h11C; #1;
    tot++; if (ld_hit !== 1'b1 || ld_data !== 64'hC0A1E5CE)
      begin bad++; $display("FAIL fill_coal got=%b/%h exp=1/c0a1e5ce", ld_hit, ld_data); end
    tot++; if (sb_empty !== 1'b0 || st_ready !== 1'b0)
      begin bad++; $display("FAIL fill_still_full got=%b/%b exp=0/0", sb_empty, st_ready); end
  endtask

  // Head is re-driven while the response is 0, then popped; the next entry follows at once.
  task automatic test_order();
    for (int c = 0; c < 4; c++) begin
      idle_in(); mem2proc_response = (c == 3) ? 4'h1 : 4'h0;
      #1;
      tot++; if (proc2mem_command !== BUS_STORE || proc2mem_addr !== 64'h100 || proc2mem_data !== 64'hA0)
        begin bad++; $display("FAIL order_hold%0d got=%0d/%h/%h exp=2/100/a0", c, proc2mem_command, proc2mem_addr, proc2mem_data); end
      tick();
    end
    idle_in(); #1;
    tot++; if (proc2mem_addr !== 64'h108) begin bad++; $display("FAIL order_next got=%h exp=108", proc2mem_addr); end
  endtask

  // Load misses own the bus; stores resume afterwards and drain in order.
  task automatic test_ldbusy();
    int n = 0;
    for (int c = 0; c < 2; c++) begin
      idle_in(); ld_busy = 1'b1; mem2proc_response = 4'h3;
      #1;
      tot++; if (proc2mem_command !== BUS_NONE) begin bad++; $display("FAIL ldbusy_none%0d got=%0d exp=0", c, proc2mem_command); end
      tick();
    end
    while (!sb_empty && n < 10) begin
      idle_in(); mem2proc_response = 4'h1;
      #1; model_eval();
      tot++; if (proc2mem_command !== BUS_STORE || proc2mem_addr !== e_addr || proc2mem_data !== e_data)
        begin bad++; $display("FAIL ldbusy_drain%0d got=%h/%h exp=%h/%h", n, proc2mem_addr, proc2mem_data, e_addr, e_data); end
      if (proc2mem_addr == 64'h118) begin
        tot++; if (proc2mem_data !== 64'hC0A1E5CE) begin bad++; $display("FAIL coal_on_bus got=%h exp=c0a1e5ce", proc2mem_data); end
      end
      tick(); n++;
    end
    tot++; if (n != 3 || sb_empty !== 1'b1) begin bad++; $display("FAIL ldbusy_count got=%0d/%b exp=3/1", n, sb_empty); end
  endtask

  task automatic test_forward();
    idle_in(); st_valid = 1'b1; st_addr = 64'h200; st_data = 64'hAAAA; tick();
    idle_in(); st_valid = 1'b1; st_addr = 64'h200; st_data = 64'hCCCC; #1;
    tot++; if (proc2mem_command !== BUS_STORE || proc2mem_addr !== 64'h200)
      begin bad++; $display("FAIL fwd_head_issued got=%0d/%h exp=2/200", proc2mem_command, proc2mem_addr); end
    tick();
    idle_in(); st_valid = 1'b1; st_addr = 64'h208; st_data = 64'hBBBB; tick();
    idle_in(); ld_busy = 1'b1; ld_addr = 64'h204; #1;
    tot++; if (ld_hit !== 1'b1 || ld_data !== 64'hCCCC) begin bad++; $display("FAIL fwd_young got=%b/%h exp=1/cccc", ld_hit, ld_data); end
    ld_addr = 64'h208; #1;
    tot++; if (ld_hit !== 1'b1 || ld_data !== 64'hBBBB) begin bad++; $display("FAIL fwd_208 got=%b/%h exp=1/bbbb", ld_hit, ld_data); end
    ld_addr = 64'h300; #1;
    tot++; if (ld_hit !== 1'b0 || ld_data !== 64'h0) begin bad++; $display("FAIL fwd_miss got=%b/%h exp=0/0", ld_hit, ld_data); end
    st_valid = 1'b1; st_addr = 64'h208; st_data = 64'hDDDD; ld_addr = 64'h208; #1;
    tot++; if (ld_hit !== 1'b1 || ld_data !== 64'hBBBB) begin bad++; $display("FAIL fwd_not_same_cycle got=%h exp=bbbb", ld_data); end
    tick();
    idle_in(); ld_busy = 1'b1; ld_addr = 64'h208; #1;
    tot++; if (ld_data !== 64'hDDDD || st_ready !== 1'b1) begin bad++; $display("FAIL fwd_coal got=%h/%b exp=dddd/1", ld_data, st_ready); end
    for (int c = 0; c < 3; c++) begin
      idle_in(); mem2proc_response = 4'h8; #1; model_eval();
      tot++; if (proc2mem_addr !== e_addr || proc2mem_data !== e_data)
        begin bad++; $display("FAIL fwd_drain%0d got=%h/%h exp=%h/%h", c, proc2mem_addr, proc2mem_data, e_addr, e_data); end
      tick();
    end
    idle_in(); #1;
    tot++; if (sb_empty !== 1'b1) begin bad++; $display("FAIL fwd_empty got=%b exp=1", sb_empty); end
  endtask

  task automatic test_halt();
    int n = 0;
    for (int k = 0; k < 2; k++) begin
      idle_in(); ld_busy = 1'b1; st_valid = 1'b1; st_addr = 64'h400 + 64'(k*8); st_data = 64'h4000 + 64'(k); tick();
    end
    idle_in(); ld_busy = 1'b1; st_valid = 1'b1; halt_req = 1'b1; st_addr = 64'h410; st_data = 64'h4002; #1;
    tot++; if (st_ready !== 1'b1) begin bad++; $display("FAIL halt_accept got=%b exp=1", st_ready); end
    tick();
    idle_in(); #1;
    tot++; if (st_ready !== 1'b0) begin bad++; $display("FAIL halt_closed got=%b exp=0", st_ready); end
    while (!sb_empty && n < 10) begin
      idle_in(); mem2proc_response = 4'h1; #1;
      tot++; if (drained !== 1'b0 || proc2mem_addr !== 64'h400 + 64'(n*8))
        begin bad++; $display("FAIL halt_drain%0d got=%b/%h exp=0/%h", n, drained, proc2mem_addr, 64'h400 + 64'(n*8)); end
      tick(); n++;
    end
    tot++; if (n != 3) begin bad++; $display("FAIL halt_count got=%0d exp=3", n); end
    idle_in(); #1;
    tot++; if (drained !== 1'b0) begin bad++; $display("FAIL halt_drained_early got=%b exp=0", drained); end
    tick();
    for (int c = 0; c < 4; c++) begin
      idle_in(); st_valid = 1'b1; st_addr = 64'h500; #1;
      tot++; if (drained !== 1'b1 || st_ready !== 1'b0 || sb_empty !== 1'b1)
        begin bad++; $display("FAIL halt_done%0d got=%b/%b/%b exp=1/0/1", c, drained, st_ready, sb_empty); end
      tick();
    end
  endtask

  task automatic test_random();
    int k;
    for (int c = 0; c < 400; c++) begin
      k = $urandom_range(0, 5);
      st_valid = ($urandom_range(0, 99) < 60);
      st_addr  = 64'h1000 + 64'(k*8) + 64'($urandom_range(0, 7));
      st_data  = {$urandom, $urandom};
      ld_busy  = ($urandom_range(0, 99) < 25);
      mem2proc_response = ($urandom_range(0, 99) < 40) ? 4'($urandom_range(1, 15)) : 4'h0;
      ld_addr  = 64'h1000 + 64'($urandom_range(0, 6) * 8) + 64'($urandom_range(0, 7));
      halt_req = (c == 300);
      #1; model_eval();
      tot++; if (st_ready !== e_ready) begin bad++; $display("FAIL rnd_ready c=%0d got=%b exp=%b", c, st_ready, e_ready); end
      tot++; if (proc2mem_command !== e_cmd || proc2mem_addr !== e_addr || proc2mem_data !== e_data)
        begin bad++; $display("FAIL rnd_bus c=%0d got=%0d/%h/%h exp=%0d/%h/%h", c, proc2mem_command, proc2mem_addr, proc2mem_data, e_cmd, e_addr, e_data); end
      tot++; if (ld_hit !== e_hit || ld_data !== e_ldata)
        begin bad++; $display("FAIL rnd_fwd c=%0d got=%b/%h exp=%b/%h", c, ld_hit, ld_data, e_hit, e_ldata); end
      tot++; if (sb_empty !== e_empty || drained !== m_drained)
        begin bad++; $display("FAIL rnd_status c=%0d got=%b/%b exp=%b/%b", c, sb_empty, drained, e_empty, m_drained); end
      tick();
    end
    tot++; if (drained !== 1'b1) begin bad++; $display("FAIL rnd_final_drained got=%b exp=1", drained); end
  endtask

  // Reset pulled while three entries are draining empties the buffer at once.
  task automatic test_reset_mid();
    do_reset();
    @(negedge clock);
    for (int k = 0; k < 3; k++) begin
      idle_in(); ld_busy = 1'b1; st_valid = 1'b1; st_addr = 64'h600 + 64'(k*8); st_data = 64'(k); tick();
    end
    idle_in(); #1;
    tot++; if (proc2mem_command !== BUS_STORE || sb_empty !== 1'b0)
      begin bad++; $display("FAIL rmid_pre got=%0d/%b exp=2/0", proc2mem_command, sb_empty); end
    reset = 1'b0; #1;
    tot++; if (sb_empty !== 1'b1 || proc2mem_command !== BUS_NONE || st_ready !== 1'b1)
      begin bad++; $display("FAIL rmid got=%b/%0d/%b exp=1/0/1", sb_empty, proc2mem_command, st_ready); end
    do_reset();
  endtask

  initial begin
    test_reset();
    test_fill();
    test_order();
    test_ldbusy();
    test_forward();
    test_halt();
    do_reset();
    @(negedge clock);
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule
